realm_log_div_pipe: RTL
=======================

// Module: realm_log_div_pipe
// PURPOSE
//  Pipelined approximate unsigned divider, Q ~= X/Y, built on Mitchell log/antilog arithmetic.
//  It is the inverse-direction companion of the REALM log-domain multiplier: log(X) - log(Y), then antilog.
//  Three stages, valid/ready on both sides, sustains 1 result/cycle.
//  Sits in the approximate-arithmetic datapath next to the multiplier and shares its LOD/normalize front end.
// PARAMETERS
//  SZ    8  operand width (X, Y); power of two, >= 4
//  M     8  kept mantissa bits incl. leading one; M==SZ exact Mitchell; M<SZ truncate, force LSB=1
//  FRAC  8  fractional bits of quotient Q
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          X/Y pair offered
//  in_ready   out  1          block accepts pair this cycle
//  in_x       in   SZ         dividend, unsigned
//  in_y       in   SZ         divisor, unsigned
//  out_valid  out  1          Q/dz valid
//  out_ready  in   1          consumer accepts result
//  out_q      out  SZ+FRAC    quotient, unsigned fixed point, FRAC fractional bits
//  out_dz     out  1          divide-by-zero flag (in_y==0)
// BEHAVIOUR
//  Handshake: transfer when valid&ready; in_valid/data held until accepted; out_* stable while out_valid&~out_ready.
//  Pipeline: S1 LOD+normalize, S2 log subtract, S3 antilog shift + special cases.
//   Per-stage valid bit; a stage loads when empty or when its content moves on this cycle.
//   in_ready = ~v1 | adv1 (combinational from out_ready through stage valids; no comb in_valid->in_ready).
//   Latency 3 cycles, accept to out_valid, unstalled. Order preserved; no drop, no duplicate.
//  Reset: all stage valids 0 -> out_valid=0, in_ready=1 next cycle; out_q=0, out_dz=0.
//   Reset mid-operation discards all in-flight pairs.
//  S1: kX = index of MS one of X (0..SZ-1), fX = (X << (SZ-1-kX))[SZ-2:0]; same for Y.
//   If M<SZ: keep top M-1 fraction bits, LSB forced 1. Flags zx=(X==0), zy=(Y==0).
//  S2: k = kX-kY (signed, clog2(SZ)+1 bits); f = fX-fY.
//   f>=0: mant = 1.f, exp = k.   f<0: mant = (2+f) i.e. 1.(f mod 1) with leading 1 kept, exp = k-1.
//   mant is 1+(M-1) bits, value in [1,2).
//  S3: Q = mant * 2^exp as SZ.FRAC fixed point; exp in [-SZ,SZ-1].
//   Right-shift bits below 2^-FRAC truncated (no rounding). Max result < 2^SZ, never overflows.
//   zy=1 -> out_q = all ones, out_dz=1 (incl. X=0,Y=0). zx=1 & zy=0 -> out_q=0, out_dz=0.
//  Simultaneous accept and emit in same cycle is normal operation; full pipeline + out_ready=1 -> in_ready=1.
// STRUCTURE
//  Shared include realm_pkg: clog2 function, SZ/LGSZ/FRAC width constants, Q width macro.
//  Sub-module realm_lod_norm (SZ,M): combinational LOD + barrel normalize -> {k, f, zero}; instantiated twice in S1.
//  Stage registers and the valid/ready chain live in this module.
// TESTING (SZ=8, M=8, FRAC=8)
//  X=200,Y=10 -> kX=7 fX=.5625, kY=3 fY=.25 -> out_q=0x1500 (21.0), out_dz=0, 3 cycles after accept.
//  X=10,Y=200 -> f<0 path, exp=-5, mant=1.6875 -> out_q=0x000D; X=77,Y=77 -> 0x0100; X=255,Y=1 -> 0xFF00.
//  Y=0 (X=5 and X=0) -> out_q=0xFFFF, out_dz=1; X=0,Y=3 -> out_q=0x0000, out_dz=0.
//  Back-to-back 16 random pairs, out_ready=1 -> one result/cycle, in order, match bit-exact C Mitchell model.
//  out_ready=0 for 6 cycles while in_valid=1 -> exactly 3 accepted, then in_ready=0; out_q held;
//   release -> remaining pairs drain in order, none lost.
//  rst asserted 1 cycle with 3 pairs in flight -> next cycle out_valid=0, in_ready=1; post-reset pair correct.

Source files
------------

// File: rtl/realm_pkg.sv
// Shared constants and width helpers for the REALM log-domain arithmetic blocks.
package realm_pkg;

  localparam int SZ_DEF   = 8;
  localparam int M_DEF    = 8;
  localparam int FRAC_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int q_width(input int sz, input int frac);
    return sz + frac;
  endfunction

endpackage

// File: rtl/realm_lod_norm.sv
// Leading-one detect and normalize: returns the MS-one index, the fraction below
// the leading one (optionally truncated to M-1 bits with LSB forced 1) and a zero flag.
module realm_lod_norm
  import realm_pkg::*;
#(
  parameter int SZ = SZ_DEF,
  parameter int M  = M_DEF
) (
  input  logic [SZ-1:0]        x,
  output logic [clog2(SZ)-1:0] k,
  output logic [M-2:0]         f,
  output logic                 zero
);

  localparam int LGSZ = clog2(SZ);

  logic [SZ-1:0] norm;

  always_comb begin
    k = '0;
    for (int i = 0; i < SZ; i++) begin
      if (x[i]) k = LGSZ'(i);
    end
  end

  // SZ is a power of two, so SZ-1-k is simply ~k.
  assign norm = x << (~k);
  assign zero = ~norm[SZ-1];

  generate
    if (M == SZ) begin : g_exact
      assign f = norm[SZ-2:0];
    end else if (M > 2) begin : g_trunc
      assign f = {norm[SZ-2 -: M-2], 1'b1};
    end else begin : g_min
      assign f = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/realm_log_div_pipe.sv
// Three-stage Mitchell log/antilog approximate divider Q ~= X/Y with a
// valid/ready chain that sustains one result per cycle.
module realm_log_div_pipe
  import realm_pkg::*;
#(
  parameter int SZ   = SZ_DEF,
  parameter int M    = M_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SZ-1:0]                 in_x,
  input  logic [SZ-1:0]                 in_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [q_width(SZ, FRAC)-1:0]  out_q,
  output logic                          out_dz
);

  localparam int LGSZ = clog2(SZ);
  localparam int KW   = LGSZ + 1;
  localparam int QW   = q_width(SZ, FRAC);
  // Antilog works on mant * 2^(exp+SZ), keeping M-1+SZ fractional bits.
  localparam int WW   = M + 2 * SZ - 1;
  localparam int DROP = M - 1 + SZ - FRAC;

  // S1: LOD + normalize for both operands
  logic [SZ-1:0]   op     [2];
  logic [LGSZ-1:0] k_s    [2];
  logic [M-2:0]    f_s    [2];
  logic            z_s    [2];

  assign op[0] = in_x;
  assign op[1] = in_y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lod
      realm_lod_norm #(.SZ(SZ), .M(M)) u_lod (
        .x    (op[gi]),
        .k    (k_s[gi]),
        .f    (f_s[gi]),
        .zero (z_s[gi])
      );
    end
  endgenerate

  logic            v1_q, v2_q, v3_q;
  logic            ready1, ready2, ready3;
  logic [LGSZ-1:0] kx_q, ky_q;
  logic [M-2:0]    fx_q, fy_q;
  logic            zx1_q, zy1_q;

  logic [M-1:0]    mant2_q, mant2_d;
  logic [KW-1:0]   exp2_q, exp2_d;
  logic            zx2_q, zy2_q;

  logic [QW-1:0]   q3_q, q3_d;
  logic            dz3_q;

  assign ready3   = ~v3_q | out_ready;
  assign ready2   = ~v2_q | ready3;
  assign ready1   = ~v1_q | ready2;
  assign in_ready = ready1;

  // S2: log subtract. A negative fraction difference already reads as 2+f in
  // M-bit two's complement, so the mantissa is always {1, low bits} and only
  // the exponent needs the borrow.
  logic [M-1:0]  f_diff;
  logic [KW-1:0] k_diff;

  assign f_diff  = {1'b0, fx_q} - {1'b0, fy_q};
  assign k_diff  = KW'(kx_q) - KW'(ky_q);
  assign mant2_d = {1'b1, f_diff[M-2:0]};
  assign exp2_d  = k_diff - {{(KW-1){1'b0}}, f_diff[M-1]};

  // S3: antilog shift plus zero-operand overrides
  logic [KW-1:0] sh;
  logic [WW-1:0] wide;

  assign sh   = exp2_q + KW'(SZ);
  assign wide = WW'(mant2_q) << sh;

  always_comb begin
    q3_d = wide[DROP +: QW];
    if (zy2_q) begin
      q3_d = '1;
    end else if (zx2_q) begin
      q3_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      kx_q    <= '0;
      ky_q    <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      zx1_q   <= 1'b0;
      zy1_q   <= 1'b0;
      mant2_q <= '0;
      exp2_q  <= '0;
      zx2_q   <= 1'b0;
      zy2_q   <= 1'b0;
      q3_q    <= '0;
      dz3_q   <= 1'b0;
    end else begin
      if (ready1) begin
        v1_q  <= in_valid;
        kx_q  <= k_s[0];
        ky_q  <= k_s[1];
        fx_q  <= f_s[0];
        fy_q  <= f_s[1];
        zx1_q <= z_s[0];
        zy1_q <= z_s[1];
      end
      if (ready2) begin
        v2_q    <= v1_q;
        mant2_q <= mant2_d;
        exp2_q  <= exp2_d;
        zx2_q   <= zx1_q;
        zy2_q   <= zy1_q;
      end
      if (ready3) begin
        v3_q  <= v2_q;
        q3_q  <= q3_d;
        dz3_q <= zy2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_q     = q3_q;
  assign out_dz    = dz3_q;

endmodule
